// File: rtl/max_pooling_layer_pkg.sv
// Shared definitions for the 2x2 stride-2 max-pooling stage.
package max_pooling_layer_pkg;

  // Widest per-channel sample the compare helper supports; narrower samples are sign-extended.
  localparam int unsigned MaxSampleWidth = 64;

  typedef logic signed [MaxSampleWidth-1:0] sample_t;

  // Signed maximum of two sign-extended samples.
  function automatic sample_t signed_max(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-row line buffer holding the horizontal maxima of the even input row.
module pool_line_buffer #(
  parameter int unsigned DEPTH = 31,
  parameter int unsigned WIDTH = 48,
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Synchronous write; contents need no reset since every read follows a write in the frame.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read.
  assign rdata = mem[raddr];

endmodule

// File: rtl/max_pooling_layer.sv
// 2x2, stride-2 max pooling over a raster-order pixel stream, all channels in parallel.
module max_pooling_layer
  import max_pooling_layer_pkg::*;
#(
  parameter int unsigned D_WIDTH      = 16,
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned IMAGE_WIDTH  = 63,
  parameter int unsigned IMAGE_HEIGHT = 31
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_en,
  input  logic [CHANNELS*D_WIDTH-1:0] input_data,
  input  logic                        input_valid,
  output logic [CHANNELS*D_WIDTH-1:0] output_data,
  output logic                        valid
);

  localparam int unsigned DataW   = CHANNELS * D_WIDTH;
  localparam int unsigned ColW    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned RowW    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int unsigned LbDepth = (IMAGE_WIDTH / 2 > 0) ? IMAGE_WIDTH / 2 : 1;
  localparam int unsigned LbAddrW = (LbDepth > 1) ? $clog2(LbDepth) : 1;

  localparam logic [ColW-1:0] ColLast = ColW'(IMAGE_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMAGE_HEIGHT - 1);

  logic [ColW-1:0]  col_q, col_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [DataW-1:0] pend_q;
  logic [DataW-1:0] out_q;
  logic             valid_q;

  logic             accept;
  logic             win_done;
  logic             lb_we;
  logic [LbAddrW-1:0] lb_addr;
  logic [DataW-1:0] lb_rdata;
  logic [DataW-1:0] h_word;
  logic [DataW-1:0] o_word;

  assign accept   = clk_en & input_valid;
  // Odd column of an odd row is the bottom-right pixel of a window.
  assign win_done = accept & col_q[0] & row_q[0];
  assign lb_we    = accept & col_q[0] & ~row_q[0];
  assign lb_addr  = LbAddrW'(col_q >> 1);

  // Per-channel horizontal max (pending vs. current) and vertical max (line buffer vs. horizontal).
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam int unsigned Lsb = (CHANNELS - 1 - c) * D_WIDTH;

    logic signed [D_WIDTH-1:0] px_c, pend_c, lb_c, h_c;

    assign px_c   = input_data[Lsb +: D_WIDTH];
    assign pend_c = pend_q[Lsb +: D_WIDTH];
    assign lb_c   = lb_rdata[Lsb +: D_WIDTH];
    assign h_c    = D_WIDTH'(signed_max(sample_t'(pend_c), sample_t'(px_c)));

    assign h_word[Lsb +: D_WIDTH] = h_c;
    assign o_word[Lsb +: D_WIDTH] = D_WIDTH'(signed_max(sample_t'(lb_c), sample_t'(h_c)));
  end

  pool_line_buffer #(
    .DEPTH(LbDepth),
    .WIDTH(DataW)
  ) u_line_buffer (
    .clk  (clk),
    .we   (lb_we),
    .waddr(lb_addr),
    .wdata(h_word),
    .raddr(lb_addr),
    .rdata(lb_rdata)
  );

  // Raster position: column wraps into row, row wraps at the frame boundary.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // State registers; a low clk_en freezes everything including the output strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      pend_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (accept && !col_q[0]) begin
        pend_q <= input_data;
      end
      if (clk_en) begin
        valid_q <= win_done;
        if (win_done) begin
          out_q <= o_word;
        end
      end
    end
  end

  assign output_data = out_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_max_pooling_layer.sv
// Bench for max_pooling_layer: a default-size instance fed ramp/random frames against a
// frame-level pooling model, and a 4x4x2 instance driven from a table of signed windows.
module tb_max_pooling_layer;

  localparam int unsigned DW = 16;
  localparam int unsigned BW = 63;
  localparam int unsigned BH = 31;
  localparam int unsigned BC = 3;
  localparam int unsigned SW = 4;
  localparam int unsigned SH = 4;
  localparam int unsigned SC = 2;
  localparam int unsigned BigPerFrame = (BW / 2) * (BH / 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-size instance.
  logic              rst_n_b, en_b, iv_b, v_b;
  logic [BC*DW-1:0]  id_b, od_b;

  // Small 4x4, two-channel instance.
  logic              rst_n_s, en_s, iv_s, v_s;
  logic [SC*DW-1:0]  id_s, od_s;

  max_pooling_layer u_big (
    .clk        (clk),
    .rst_n      (rst_n_b),
    .clk_en     (en_b),
    .input_data (id_b),
    .input_valid(iv_b),
    .output_data(od_b),
    .valid      (v_b)
  );

  max_pooling_layer #(
    .D_WIDTH     (DW),
    .CHANNELS    (SC),
    .IMAGE_WIDTH (SW),
    .IMAGE_HEIGHT(SH)
  ) u_small (
    .clk        (clk),
    .rst_n      (rst_n_s),
    .clk_en     (en_s),
    .input_data (id_s),
    .input_valid(iv_s),
    .output_data(od_s),
    .valid      (v_s)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One 2x2 window of channel 0 (channel 1 is its negation) with hand-derived maxima.
  typedef struct packed {
    logic signed [15:0] tl;
    logic signed [15:0] tr;
    logic signed [15:0] bl;
    logic signed [15:0] br;
    logic signed [15:0] exp0;
    logic signed [15:0] exp1;
  } win_t;

  win_t tbl [4];

  function automatic logic [SC*DW-1:0] small_px(input int r, input int c, input bit neg);
    win_t w;
    logic signed [15:0] v;
    w = tbl[(r / 2) * 2 + c / 2];
    case ((r % 2) * 2 + c % 2)
      0:       v = w.tl;
      1:       v = w.tr;
      2:       v = w.bl;
      default: v = w.br;
    endcase
    if (neg) v = -v;
    return {v, -v};
  endfunction

  // Small-instance monitor state.
  logic [SC*DW-1:0] got_s [$];
  logic             en_last_s = 1'b0;
  logic             pv_s = 1'b0;
  logic [SC*DW-1:0] pd_s = '0;

  // Big-instance reference data.
  logic [BC*DW-1:0] frm [BH][BW];
  logic [BC*DW-1:0] exp_b [$];
  int               big_cnt = 0;

  always @(posedge clk) en_last_s <= en_s;

  // Sample both instances on the falling edge.
  always @(negedge clk) begin
    if (rst_n_s) begin
      if (!en_last_s) begin
        check("stall_hold", 64'({v_s, od_s}), 64'({pv_s, pd_s}));
      end else if (v_s) begin
        got_s.push_back(od_s);
      end
    end
    pv_s = v_s;
    pd_s = od_s;
    if (rst_n_b && v_b) begin
      big_cnt++;
      if (exp_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL big_extra_output: got %0h, expected no output", od_b);
      end else begin
        check("big_pixel", 64'(od_b), 64'(exp_b.pop_front()));
      end
    end
  end

  // Fill a big frame (ramp or random) and queue its pooled outputs from the 2x2 window rule.
  task automatic build_big(input bit ramp);
    logic [BC*DW-1:0] e;
    int m, v;
    for (int r = 0; r < BH; r++) begin
      for (int c = 0; c < BW; c++) begin
        for (int ch = 0; ch < BC; ch++) begin
          frm[r][c][(BC-1-ch)*DW +: DW] = ramp ? 16'(r * 64 + c) : 16'($urandom);
        end
      end
    end
    for (int i = 0; i < BH / 2; i++) begin
      for (int j = 0; j < BW / 2; j++) begin
        for (int ch = 0; ch < BC; ch++) begin
          m = -(2 ** 30);
          for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
              v = $signed(frm[2*i+dr][2*j+dc][(BC-1-ch)*DW +: DW]);
              if (v > m) m = v;
            end
          end
          e[(BC-1-ch)*DW +: DW] = m[15:0];
        end
        exp_b.push_back(e);
      end
    end
  endtask

  task automatic send_big(input bit bubbles);
    for (int r = 0; r < BH; r++) begin
      for (int c = 0; c < BW; c++) begin
        if (bubbles && $urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
          iv_b = 1'b0;
          id_b = 48'($urandom);
        end
        @(posedge clk); #1;
        iv_b = 1'b1;
        id_b = frm[r][c];
      end
    end
    @(posedge clk); #1;
    iv_b = 1'b0;
  endtask

  // Stream the first n pixels of the table frame, optionally with bubbles and a 3-cycle stall.
  task automatic send_small(input bit neg, input bit bubbles, input bit stall, input int n);
    for (int idx = 0; idx < n; idx++) begin
      if (bubbles && (idx % 2 == 1)) begin
        @(posedge clk); #1;
        iv_s = 1'b0;
        id_s = 32'hdead_beef;
      end
      if (stall && idx == 6) begin
        @(posedge clk); #1;
        en_s = 1'b0;
        iv_s = 1'b1;
        id_s = 32'h7fff_7fff;
        repeat (3) @(posedge clk);
        #1;
        en_s = 1'b1;
        iv_s = 1'b0;
      end
      @(posedge clk); #1;
      iv_s = 1'b1;
      id_s = small_px(idx / 4, idx % 4, neg);
    end
    @(posedge clk); #1;
    iv_s = 1'b0;
  endtask

  task automatic check_small(input string tag, input bit neg);
    logic [SC*DW-1:0] e;
    for (int w = 0; w < 4; w++) begin
      e = neg ? {tbl[w].exp1, tbl[w].exp0} : {tbl[w].exp0, tbl[w].exp1};
      if (got_s.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s_missing: got no output, expected %0h", tag, e);
      end else begin
        check(tag, 64'(got_s.pop_front()), 64'(e));
      end
    end
  endtask

  initial begin
    tbl[0] = '{-16'sd5,     16'sd3,      -16'sd2,   -16'sd8,    16'sd3,     16'sd8};
    tbl[1] = '{16'sd7,      -16'sd1,     16'sd0,    16'sd9,     16'sd9,     16'sd1};
    tbl[2] = '{-16'sd32767, -16'sd30000, -16'sd100, -16'sd32767, -16'sd100, 16'sd32767};
    tbl[3] = '{16'sd32767,  16'sd0,      -16'sd1,   16'sd1,     16'sd32767, 16'sd1};

    rst_n_b = 1'b0; en_b = 1'b1; iv_b = 1'b0; id_b = '0;
    rst_n_s = 1'b0; en_s = 1'b1; iv_s = 1'b0; id_s = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid_big", 64'(v_b), 64'(0));
    check("reset_data_big", 64'(od_b), 64'(0));
    check("reset_valid_small", 64'(v_s), 64'(0));
    check("reset_data_small", 64'(od_s), 64'(0));
    rst_n_b = 1'b1;
    rst_n_s = 1'b1;

    // Ramp frame on the default instance.
    build_big(1'b1);
    send_big(1'b0);
    repeat (3) @(posedge clk);
    check("big_ramp_count", 64'(big_cnt), 64'(BigPerFrame));

    // Two random frames with bubbles, streamed back to back.
    build_big(1'b0);
    send_big(1'b1);
    build_big(1'b0);
    send_big(1'b1);
    repeat (3) @(posedge clk);
    check("big_total_count", 64'(big_cnt), 64'(3 * BigPerFrame));
    check("big_leftover", 64'(exp_b.size()), 64'(0));

    // Plain signed 4x4 frame.
    send_small(1'b0, 1'b0, 1'b0, 16);
    repeat (2) @(posedge clk);
    check("small_plain_count", 64'(got_s.size()), 64'(4));
    check_small("small_plain", 1'b0);

    // Same frame with bubbles and a clk_en stall during row 1.
    send_small(1'b0, 1'b1, 1'b1, 16);
    repeat (2) @(posedge clk);
    check("small_stall_count", 64'(got_s.size()), 64'(4));
    check_small("small_stall", 1'b0);

    // Two frames back to back with different data.
    send_small(1'b0, 1'b0, 1'b0, 16);
    send_small(1'b1, 1'b0, 1'b0, 16);
    repeat (2) @(posedge clk);
    check("small_b2b_count", 64'(got_s.size()), 64'(8));
    check_small("small_b2b_f0", 1'b0);
    check_small("small_b2b_f1", 1'b1);

    // Asynchronous reset in the middle of row 1, right after the first window completes.
    send_small(1'b0, 1'b0, 1'b0, 6);
    check("pre_reset_valid", 64'(v_s), 64'(1));
    check("pre_reset_data", 64'(od_s), 64'({tbl[0].exp0, tbl[0].exp1}));
    #1;
    rst_n_s = 1'b0;
    #1;
    check("async_reset_valid", 64'(v_s), 64'(0));
    check("async_reset_data", 64'(od_s), 64'(0));
    #2;
    rst_n_s = 1'b1;
    got_s.delete();
    send_small(1'b1, 1'b0, 1'b0, 16);
    repeat (2) @(posedge clk);
    check("small_post_reset_count", 64'(got_s.size()), 64'(4));
    check_small("small_post_reset", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/max_pooling_layer.md
Name: max_pooling_layer

Overview:
- 2x2, stride-2 max-pooling stage placed directly downstream of convolutional_layer.
- Consumes that layer's per-pixel output stream (output_data/valid) in raster order and emits one pooled pixel per 2x2 window, all channels in parallel.
- Holds half an input row of horizontal maxima in a line buffer, so no full-frame storage is needed.

Parameters:
- D_WIDTH, 16, bits per channel sample; signed two's complement, matching the convolutional_layer Q_WIDTH.
- CHANNELS, 3, number of channels packed in one word; matches the convolutional_layer Q_CHANNELS.
- IMAGE_WIDTH, 63, input pixels per row (conv output width).
- IMAGE_HEIGHT, 31, input rows per frame (conv output height).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clk_en  input  1  global stall; when low every register holds its value.
- input_data  input  CHANNELS*D_WIDTH  input pixel; channel 0 in the MSBs.
- input_valid  input  1  input_data is a valid pixel this cycle.
- output_data  output  CHANNELS*D_WIDTH  pooled pixel, same packing as input_data.
- valid  output  1  one-cycle strobe marking output_data valid.

Behaviour:
- Reset (async assert, sync release): valid=0, output_data=0, col=0, row=0, pending-pixel register=0. Line-buffer contents are don't-care.
- A pixel is accepted only when clk_en=1 and input_valid=1. When clk_en=0, nothing changes, including valid and output_data. input_valid is ignored while clk_en=0.
- Counters:
  - col runs 0..IMAGE_WIDTH-1 and wraps to 0, incrementing row.
  - row runs 0..IMAGE_HEIGHT-1 and wraps to 0, which is the frame boundary.
- Per-channel comparison: signed max, independent per channel, no width growth.
- Even col: store the pixel into the pending register.
- Odd col: h = max(pending, pixel).
  - Even row: write h into the line buffer at address col>>1. No output.
  - Odd row: register max(linebuf[col>>1], h) into output_data and assert valid for exactly one accepted-cycle.
- Latency: valid rises on the clock edge that accepts the bottom-right pixel of the window (1 register stage). valid drops the next enabled cycle unless another window completes.
- Odd IMAGE_WIDTH: the last column (col=IMAGE_WIDTH-1 when even) is stored in pending but never used. Pending is overwritten at col 0 of the next row.
- Odd IMAGE_HEIGHT: the last row (row=IMAGE_HEIGHT-1 when even) writes the line buffer but produces no output. The next frame's row 0 overwrites it.
- Output per frame: (IMAGE_WIDTH/2)*(IMAGE_HEIGHT/2) pixels, integer division. Defaults give 31*15 = 465.
- Line buffer:
  - Depth IMAGE_WIDTH/2, width CHANNELS*D_WIDTH.
  - Write and read in the same cycle never alias, because writes happen only on even rows and reads only on odd rows.
- Gaps in input_valid (bubbles) are allowed anywhere, including mid-window. Only accepted pixels advance state.
- Reset mid-frame: counters return to 0 immediately. The next accepted pixel is treated as (row 0, col 0).

Decomposition:
- Shared definitions file gets a signed_max(a,b) function. PERIOD stays where it is.
- Line buffer as sub-module pool_line_buffer: parameters DEPTH and WIDTH, synchronous write, combinational read.
- Counters and compare logic stay in max_pooling_layer.

Test Plan:
- Defaults, 63x31 ramp frame, pixel(r,c) = r*64+c on all channels → exactly 465 valid strobes. Pooled (i,j) = (2i+1)*64 + 2j+1. The col-62 and row-30 inputs never appear.
- IMAGE_WIDTH=4, IMAGE_HEIGHT=4, CHANNELS=2, signed inputs:
  - Stimulus row0 = {-5,3,7,-1}, row1 = {-2,-8,0,9}; channel 1 = negated channel 0.
  - Expected ch0 outputs 3 and 9.
  - Expected ch1 outputs 8 and 1.
- Same 4x4 with input_valid low on alternate cycles and clk_en low for 3 cycles during row 1 → identical outputs. valid and output_data hold through the stall and never duplicate.
- Two back-to-back 4x4 frames with different data → 4 outputs each. The second frame's outputs do not depend on the first frame's buffer contents.
- rst_n pulsed low asynchronously (between edges) in the middle of row 1 of a 4x4 frame:
  - valid=0 and output_data=0 immediately.
  - A complete fresh frame afterwards produces the correct 4 outputs.
- Continuous 63x31 frames streamed directly from a convolutional_layer instance (D_CHANNELS=2, Q_CHANNELS=3) → output count per frame = 465 and pixel values match the reference model.
